adc_capture_arbiter: RTL and testbench
======================================

# adc_capture_arbiter

Shares the single 16-bit capture FIFO between the two AD9226 channels on the 256 MHz sampling clock. It grants the FIFO to one requesting channel at a time using round-robin priority, then sequences that channel through clear, capture of N samples, and hold-for-readout. It releases the FIFO when the SPI readout side signals completion. It owns the FIFO write port (aclr, wrreq, data); the read port belongs to the readout logic.

## Interface
Parameters:
- CLR_CYC, 4: number of cycles fifo_aclr is held high in CLEAR (legal range 1..15).

Ports:
- clk  in  1  capture clock (clk_256M).
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  2  capture request per channel; level, sampled only in IDLE.
- sample_num  in  16  samples to capture; latched on grant.
- adc_valid  in  2  per-channel sample strobe, one cycle per sample.
- adc_data0  in  12  channel 0 sample.
- adc_data1  in  12  channel 1 sample.
- adc_otr  in  2  per-channel out-of-range bit, qualified by adc_valid.
- rd_done  in  1  one-cycle pulse from readout: FIFO drained.
- abort  in  1  one-cycle pulse: cancel the current transaction.
- fifo_wrfull  in  1  FIFO write-side full.
- grant  out  2  one-hot owner; 2'b00 when idle.
- busy  out  1  high in any state except IDLE.
- cap_ready  out  1  high in READY.
- overflow  out  1  sticky: a sample was dropped in the current transaction.
- cap_count  out  16  samples written in the current transaction.
- fifo_aclr  out  1  FIFO asynchronous clear.
- fifo_wrreq  out  1  FIFO write request.
- fifo_di  out  16  FIFO write data.

## Operation
- All outputs are registered and reset to 0. The round-robin pointer resets to 0, so channel 0 wins the first tie.
- States: IDLE, CLEAR, CAPTURE, READY.
- IDLE: a channel is eligible when its req bit is set.
  - If one channel is eligible, grant that channel.
  - If both are eligible, grant the channel selected by the pointer.
  - On grant: latch sample_num, clear cap_count and overflow, go to CLEAR.
- CLEAR: hold fifo_aclr high for CLR_CYC cycles, then go to CAPTURE.
  - If the latched sample_num is 0, go to READY instead of CAPTURE.
- CAPTURE: each cycle with adc_valid[g] set (g = granted channel) produces a write on the next cycle.
  - Write data: fifo_di = {g, otr_g, 2'b00, data_g[11:0]}.
  - adc_valid of the non-granted channel is ignored.
- fifo_wrfull high in the cycle a sample arrives:
  - no wrreq for that sample;
  - overflow is set;
  - the state goes to READY.
- When cap_count reaches the latched sample_num, go to READY. cap_count never exceeds it.
- READY: grant is held and cap_ready is high until rd_done.
  - On rd_done: pointer becomes the other channel (~g), grant clears, state goes to IDLE.
  - rd_done in any other state is ignored.
- abort in any non-IDLE state: go to IDLE with a one-cycle fifo_aclr pulse.
  - grant clears; the pointer advances as if rd_done had arrived.
  - overflow and cap_count keep their values until the next grant.
- Priority when events coincide: abort beats everything else; rd_done beats a new request in the same cycle.
- Changes to req or sample_num after the grant have no effect.

## Timing
- Request → grant: req high in IDLE at cycle t gives grant and busy at t+1. fifo_aclr is high for t+1 .. t+CLR_CYC; CAPTURE begins at t+CLR_CYC+1.
- Write latency: adc_valid at cycle c gives fifo_wrreq and fifo_di at c+1, and cap_count increments at c+1.
- Last sample: the N-th adc_valid at c gives the final wrreq at c+1 and cap_ready at c+1. One sample per cycle is sustained.
- Release: rd_done at r gives grant=0, cap_ready=0 and busy=0 at r+1. A new grant is possible at r+2 at the earliest.
- Abort: abort at a gives fifo_aclr=1 and grant=0 at a+1, then fifo_aclr=0 at a+2. Any adc_valid at cycle a is not written.
- Reset mid-transaction: all outputs return to 0 immediately. The pointer returns to 0.

## Test plan
- Reset, then req=2'b01, sample_num=4, four adc_valid[0] with data 0x001..0x004 → grant=01, then 4 aclr cycles, then fifo_di 0x0001..0x0004, cap_count=4, cap_ready. rd_done → grant=00.
- req=2'b11 held through three transactions → grants 01, 10, 01. Each release takes rd_done.
- Channel 1 granted, sample_num=3, adc_otr[1]=1 on the second sample, interleaved adc_valid[0] strobes → fifo_di = 0x8xxx, 0xCxxx, 0x8xxx. No channel-0 writes.
- sample_num=8 with fifo_wrfull asserted before sample 5 → four writes, overflow=1, cap_count=4, READY.
- abort during CAPTURE after 2 of 10 samples → one-cycle fifo_aclr pulse, grant=00, cap_count stays 2. Next tie is won by the other channel.
- sample_num=0 → CLEAR, then READY with cap_count=0 and no wrreq. rd_done asserted in IDLE has no effect.

Source files
------------

// File: rtl/adc_capture_arbiter.sv
// adc_capture_arbiter
// Shares one 16-bit capture FIFO between two ADC channels. A requesting
// channel is granted round-robin, then the FIFO is cleared, N samples are
// captured, and the FIFO is held for readout until rd_done or abort.
//
// Ports
//   clk, rst_n            capture clock, async active-low reset
//   req[1:0]              per-channel capture request (sampled in IDLE)
//   sample_num[15:0]      samples per transaction, latched on grant
//   adc_valid[1:0]        per-channel sample strobe
//   adc_data0/1[11:0]     channel samples
//   adc_otr[1:0]          per-channel out-of-range flag
//   rd_done, abort        readout-complete / cancel pulses
//   fifo_wrfull           FIFO write-side full
//   grant[1:0]            one-hot owner, 0 when idle
//   busy, cap_ready       not-idle / holding data for readout
//   overflow, cap_count   sticky drop flag / samples written
//   fifo_aclr, fifo_wrreq, fifo_di   FIFO write port
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | no owner, waiting for a request
// CLEAR   | fifo_aclr held high for CLR_CYC cycles
// CAPTURE | writing granted channel samples into the FIFO
// READY   | FIFO holds data, waiting for rd_done
module adc_capture_arbiter #(
    parameter int unsigned CLR_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] sample_num,
    input  logic [1:0]  adc_valid,
    input  logic [11:0] adc_data0,
    input  logic [11:0] adc_data1,
    input  logic [1:0]  adc_otr,
    input  logic        rd_done,
    input  logic        abort,
    input  logic        fifo_wrfull,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        cap_ready,
    output logic        overflow,
    output logic [15:0] cap_count,
    output logic        fifo_aclr,
    output logic        fifo_wrreq,
    output logic [15:0] fifo_di
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_CAPTURE,
        S_READY
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        ptr_q, ptr_d;
    logic [15:0] num_q, num_d;
    logic [15:0] cap_count_q, cap_count_d;
    logic        overflow_q, overflow_d;
    logic        aclr_q, aclr_d;
    logic        wrreq_q, wrreq_d;
    logic [15:0] di_q, di_d;
    logic        busy_q, busy_d;
    logic        cap_ready_q, cap_ready_d;
    logic [3:0]  clr_cnt_q, clr_cnt_d;

    logic        ch;
    logic        sel;
    logic        vld_g;
    logic        otr_g;
    logic [11:0] data_g;
    logic [15:0] cnt_inc;

    // Channel index of the current owner (grant is one-hot).
    assign ch      = grant_q[1];
    assign vld_g   = ch ? adc_valid[1] : adc_valid[0];
    assign otr_g   = ch ? adc_otr[1]   : adc_otr[0];
    assign data_g  = ch ? adc_data1    : adc_data0;
    assign cnt_inc = cap_count_q + 16'd1;
    // Tie goes to the pointer; otherwise the single requester wins.
    assign sel     = (req == 2'b11) ? ptr_q : req[1];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        num_d       = num_q;
        cap_count_d = cap_count_q;
        overflow_d  = overflow_q;
        aclr_d      = 1'b0;
        wrreq_d     = 1'b0;
        di_d        = di_q;
        clr_cnt_d   = clr_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    grant_d     = sel ? 2'b10 : 2'b01;
                    num_d       = sample_num;
                    cap_count_d = '0;
                    overflow_d  = 1'b0;
                    clr_cnt_d   = 4'(CLR_CYC - 1);
                    aclr_d      = 1'b1;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == 4'd0) begin
                    state_d = (num_q == 16'd0) ? S_READY : S_CAPTURE;
                end else begin
                    clr_cnt_d = clr_cnt_q - 4'd1;
                    aclr_d    = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (vld_g) begin
                    if (fifo_wrfull) begin
                        overflow_d = 1'b1;
                        state_d    = S_READY;
                    end else begin
                        wrreq_d     = 1'b1;
                        di_d        = {ch, otr_g, 2'b00, data_g};
                        cap_count_d = cnt_inc;
                        if (cnt_inc == num_q) begin
                            state_d = S_READY;
                        end
                    end
                end
            end
            S_READY: begin
                if (rd_done) begin
                    ptr_d   = ~ch;
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything; counters stay visible until next grant.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            grant_d     = 2'b00;
            ptr_d       = ~ch;
            aclr_d      = 1'b1;
            wrreq_d     = 1'b0;
            di_d        = di_q;
            cap_count_d = cap_count_q;
            overflow_d  = overflow_q;
        end
    end

    assign busy_d      = (state_d != S_IDLE);
    assign cap_ready_d = (state_d == S_READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            ptr_q       <= 1'b0;
            num_q       <= '0;
            cap_count_q <= '0;
            overflow_q  <= 1'b0;
            aclr_q      <= 1'b0;
            wrreq_q     <= 1'b0;
            di_q        <= '0;
            busy_q      <= 1'b0;
            cap_ready_q <= 1'b0;
            clr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            num_q       <= num_d;
            cap_count_q <= cap_count_d;
            overflow_q  <= overflow_d;
            aclr_q      <= aclr_d;
            wrreq_q     <= wrreq_d;
            di_q        <= di_d;
            busy_q      <= busy_d;
            cap_ready_q <= cap_ready_d;
            clr_cnt_q   <= clr_cnt_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = busy_q;
    assign cap_ready  = cap_ready_q;
    assign overflow   = overflow_q;
    assign cap_count  = cap_count_q;
    assign fifo_aclr  = aclr_q;
    assign fifo_wrreq = wrreq_q;
    assign fifo_di    = di_q;

endmodule

// File: tb/tb_adc_capture_arbiter.sv
// Randomized bench for adc_capture_arbiter: each transaction is predicted
// from the arbitration/capture rules (owner, write stream, counts, flags).
module tb_adc_capture_arbiter;

    localparam int CLR = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] sample_num;
    logic [1:0]  adc_valid;
    logic [11:0] adc_data0;
    logic [11:0] adc_data1;
    logic [1:0]  adc_otr;
    logic        rd_done;
    logic        abort;
    logic        fifo_wrfull;
    logic [1:0]  grant;
    logic        busy;
    logic        cap_ready;
    logic        overflow;
    logic [15:0] cap_count;
    logic        fifo_aclr;
    logic        fifo_wrreq;
    logic [15:0] fifo_di;

    int n_checks = 0;
    int n_errors = 0;
    int ptr      = 0;   // model: channel that wins the next tie
    int exp_wr   = 0;
    int wr_seen  = 0;

    adc_capture_arbiter #(.CLR_CYC(CLR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .sample_num (sample_num),
        .adc_valid  (adc_valid),
        .adc_data0  (adc_data0),
        .adc_data1  (adc_data1),
        .adc_otr    (adc_otr),
        .rd_done    (rd_done),
        .abort      (abort),
        .fifo_wrfull(fifo_wrfull),
        .grant      (grant),
        .busy       (busy),
        .cap_ready  (cap_ready),
        .overflow   (overflow),
        .cap_count  (cap_count),
        .fifo_aclr  (fifo_aclr),
        .fifo_wrreq (fifo_wrreq),
        .fifo_di    (fifo_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (fifo_wrreq) wr_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic noise();
        adc_valid = 2'($urandom_range(3));
        adc_data0 = 12'($urandom_range(4095));
        adc_data1 = 12'($urandom_range(4095));
        adc_otr   = 2'($urandom_range(3));
    endtask

    task automatic quiet();
        req = 2'b00; adc_valid = 2'b00; rd_done = 1'b0;
        abort = 1'b0; fifo_wrfull = 1'b0;
    endtask

    // mode 0: random strobes/data; 1: every cycle, data cnt+1, otr 0;
    // 2: like 1 but otr set on the second sample.
    task automatic run_txn(input logic [1:0] rq, input int n, input int full_at,
                           input int abort_at, input int mode);
        int g, cnt, iter, d, o, hold;
        bit vg, done, ab, ovf;
        g = (rq == 2'b11) ? ptr : (rq[1] ? 1 : 0);
        quiet();
        req = rq; sample_num = 16'(n);
        tick();
        chk("grant", grant, (g == 1) ? 2'b10 : 2'b01);
        chk("busy_on_grant", busy, 1);
        chk("aclr_first", fifo_aclr, 1);
        chk("count_cleared", cap_count, 0);
        chk("ovf_cleared", overflow, 0);
        req = 2'($urandom_range(3)); sample_num = 16'($urandom);
        for (int k = 2; k <= CLR; k++) begin
            noise(); tick();
            chk("aclr_hold", fifo_aclr, 1);
            chk("no_wr_clear", fifo_wrreq, 0);
        end
        noise(); tick();
        chk("aclr_end", fifo_aclr, 0);
        chk("no_wr_clear_end", fifo_wrreq, 0);
        adc_valid = 2'b00;
        cnt = 0; ovf = 0; done = (n == 0); iter = 0;
        if (n == 0) begin
            chk("zero_ready", cap_ready, 1);
            chk("zero_count", cap_count, 0);
        end
        while (!done) begin
            iter++;
            if (iter > 2000) begin
                chk("capture_timeout", iter, 0);
                quiet();
                return;
            end
            vg = (mode != 0) ? 1'b1 : ($urandom_range(3) != 0);
            d  = (mode != 0) ? cnt + 1 : $urandom_range(4095);
            o  = (mode == 2) ? int'(cnt == 1) : ((mode == 1) ? 0 : $urandom_range(1));
            noise();
            adc_valid[g] = vg;
            adc_otr[g]   = 1'(o);
            if (g == 0) adc_data0 = 12'(d); else adc_data1 = 12'(d);
            fifo_wrfull = (cnt == full_at);
            ab = (cnt == abort_at);
            abort = ab;
            tick();
            if (ab) begin
                chk("abort_aclr", fifo_aclr, 1);
                chk("abort_grant", grant, 0);
                chk("abort_busy", busy, 0);
                chk("abort_no_wr", fifo_wrreq, 0);
                chk("abort_count", cap_count, cnt);
                ptr = 1 - g;
                quiet();
                tick();
                chk("abort_aclr_off", fifo_aclr, 0);
                chk("abort_count_kept", cap_count, cnt);
                chk("abort_grant_off", grant, 0);
                chk("wr_total", wr_seen, exp_wr);
                return;
            end else if (vg && fifo_wrfull) begin
                ovf = 1;
                chk("full_no_wr", fifo_wrreq, 0);
                chk("full_ovf", overflow, 1);
                chk("full_ready", cap_ready, 1);
                chk("full_count", cap_count, cnt);
                done = 1;
            end else if (vg) begin
                cnt++; exp_wr++;
                chk("wrreq", fifo_wrreq, 1);
                chk("di", fifo_di, (g << 15) | (o << 14) | d);
                chk("count", cap_count, cnt);
                chk("ready_at_last", cap_ready, int'(cnt == n));
                done = (cnt == n);
            end else begin
                chk("idle_no_wr", fifo_wrreq, 0);
                chk("count_hold", cap_count, cnt);
                chk("not_ready", cap_ready, 0);
            end
        end
        fifo_wrfull = 1'b0;
        hold = $urandom_range(1, 3);
        for (int k = 0; k < hold; k++) begin
            noise(); req = 2'($urandom_range(3));
            tick();
            chk("ready_grant", grant, (g == 1) ? 2'b10 : 2'b01);
            chk("ready_flag", cap_ready, 1);
            chk("ready_busy", busy, 1);
            chk("ready_no_wr", fifo_wrreq, 0);
            chk("ready_count", cap_count, cnt);
        end
        adc_valid = 2'b00;
        rd_done = 1'b1; req = 2'($urandom_range(1, 3));
        tick();
        chk("rel_grant", grant, 0);
        chk("rel_ready", cap_ready, 0);
        chk("rel_busy", busy, 0);
        chk("rel_ovf_kept", overflow, ovf);
        ptr = 1 - g;
        quiet();
        chk("wr_total", wr_seen, exp_wr);
    endtask

    initial begin
        int rq, n, sel, fa, aa;
        rst_n = 1'b0;
        quiet();
        sample_num = '0; adc_data0 = '0; adc_data1 = '0; adc_otr = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_aclr", fifo_aclr, 0);
        chk("rst_wrreq", fifo_wrreq, 0);
        chk("rst_count", cap_count, 0);
        rst_n = 1'b1;
        tick();

        run_txn(2'b01, 4, -1, -1, 1);
        run_txn(2'b11, 3, -1, -1, 0);
        run_txn(2'b11, 3, -1, -1, 0);
        run_txn(2'b11, 3, -1, -1, 0);
        run_txn(2'b10, 3, -1, -1, 2);
        run_txn(2'b01, 8, 4, -1, 1);
        run_txn(2'b11, 10, -1, 2, 0);
        run_txn(2'b11, 2, -1, -1, 0);
        run_txn(2'b01, 0, -1, -1, 0);

        // rd_done while idle must not move the tie pointer.
        rd_done = 1'b1;
        tick();
        chk("idle_rd_grant", grant, 0);
        chk("idle_rd_busy", busy, 0);
        rd_done = 1'b0;
        run_txn(2'b11, 1, -1, -1, 0);

        for (int i = 0; i < 40; i++) begin
            rq = $urandom_range(1, 3);
            n = $urandom_range(0, 10);
            sel = $urandom_range(0, 3);
            fa = -1; aa = -1;
            if (n > 0 && sel == 0) fa = $urandom_range(0, n - 1);
            if (n > 0 && sel == 1) aa = $urandom_range(0, n - 1);
            run_txn(2'(rq), n, fa, aa, 0);
        end

        // Reset in the middle of a transaction, pointer left at channel 1.
        run_txn(2'b01, 1, -1, -1, 0);
        req = 2'b11; sample_num = 16'd5;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_aclr", fifo_aclr, 0);
        chk("midrst_busy", busy, 0);
        quiet();
        @(negedge clk);
        rst_n = 1'b1;
        ptr = 0;
        run_txn(2'b11, 2, -1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
